// File: rtl/mining_pkg.sv
// Shared widths, state encoding and a small state helper for the nonce search controller.
package mining_pkg;

  localparam int SEED_W   = 256;
  localparam int NONCE_W  = 32;
  localparam int MSG_W    = 288;
  localparam int DIGEST_W = 256;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    REQ     = 3'd2,
    CHECK   = 3'd3,
    FOUND   = 3'd4,
    EXHAUST = 3'd5
  } search_state_t;

  function automatic logic state_is_busy(input search_state_t st);
    case (st)
      IDLE, FOUND, EXHAUST: return 1'b0;
      default:              return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// Generator, hash-core and status signals of the nonce search controller.
// The attempts counter is present only when NONCE_SEARCH_STATS_EN is defined.
interface nonce_search_ctrl_if;
  import mining_pkg::*;

  logic                seq_valid;
  logic [MSG_W-1:0]    seq_data;
  logic                start;
  logic                hash_req;
  logic [MSG_W-1:0]    hash_msg;
  logic                hash_done;
  logic [DIGEST_W-1:0] hash_digest;
  logic                busy;
  logic                found;
  logic                exhausted;
  logic [NONCE_W-1:0]  nonce_out;
  logic [DIGEST_W-1:0] digest_out;
`ifdef NONCE_SEARCH_STATS_EN
  logic [NONCE_W-1:0]  attempts;
`endif

  modport master (
    input  seq_valid, seq_data, start, hash_done, hash_digest,
    output hash_req, hash_msg, busy, found, exhausted, nonce_out, digest_out
`ifdef NONCE_SEARCH_STATS_EN
    , output attempts
`endif
  );

  modport slave (
    output seq_valid, seq_data, start, hash_done, hash_digest,
    input  hash_req, hash_msg, busy, found, exhausted, nonce_out, digest_out
`ifdef NONCE_SEARCH_STATS_EN
    , input attempts
`endif
  );

endinterface

// File: rtl/target_compare.sv
// Leading-zero difficulty test: hit when the top DIFFICULTY digest bits are all zero.
module target_compare
  import mining_pkg::*;
#(
  parameter int DIFFICULTY = 8
) (
  input  logic [DIGEST_W-1:0] digest,
  output logic                hit
);

  generate
    if (DIFFICULTY == 0) begin : g_no_target
      logic unused_digest_s;
      assign hit             = 1'b1;
      assign unused_digest_s = ^digest;
    end else begin : g_target
      assign hit = (digest[DIGEST_W-1 -: DIFFICULTY] == {DIFFICULTY{1'b0}});
      if (DIFFICULTY < DIGEST_W) begin : g_low_bits
        logic unused_low_s;
        assign unused_low_s = ^digest[DIGEST_W-DIFFICULTY-1:0];
      end
    end
  endgenerate

endmodule

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: walks nonces through an external hash core until a digest meets the
// difficulty target or the nonce space ends. Define NONCE_SEARCH_STATS_EN for the attempts counter.
module nonce_search_ctrl
  import mining_pkg::*;
#(
  parameter int                 DIFFICULTY  = 8,
  parameter logic [NONCE_W-1:0] NONCE_START = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  nonce_search_ctrl_if.master bus
);

  search_state_t       state_r;
  search_state_t       state_s;
  logic [SEED_W-1:0]   block_r;
  logic [NONCE_W-1:0]  nonce_r;
  logic [DIGEST_W-1:0] digest_r;
  logic [NONCE_W-1:0]  nonce_out_r;
  logic [DIGEST_W-1:0] digest_out_r;
  logic                found_r;
  logic                exhausted_r;
  logic                hash_req_r;
  logic                busy_r;
  logic                hit_s;
  logic                start_ok_s;
  logic                last_nonce_s;
  logic                unused_nonce_field_s;

  target_compare #(.DIFFICULTY(DIFFICULTY)) u_target (
    .digest (digest_r),
    .hit    (hit_s)
  );

  assign start_ok_s           = bus.start & bus.seq_valid;
  assign last_nonce_s         = (nonce_r == 32'hFFFF_FFFF);
  assign unused_nonce_field_s = ^bus.seq_data[NONCE_W-1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE, FOUND, EXHAUST: begin
        if (start_ok_s) state_s = LOAD;
        else            state_s = state_r;
      end
      LOAD: state_s = REQ;
      REQ: begin
        if (bus.hash_done) state_s = CHECK;
        else               state_s = REQ;
      end
      CHECK: begin
        if (hit_s)             state_s = FOUND;
        else if (last_nonce_s) state_s = EXHAUST;
        else                   state_s = REQ;
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs; hash_req/busy follow the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_r      <= {SEED_W{1'b0}};
      nonce_r      <= {NONCE_W{1'b0}};
      digest_r     <= {DIGEST_W{1'b0}};
      nonce_out_r  <= {NONCE_W{1'b0}};
      digest_out_r <= {DIGEST_W{1'b0}};
      found_r      <= 1'b0;
      exhausted_r  <= 1'b0;
      hash_req_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      hash_req_r <= (state_s == REQ);
      busy_r     <= state_is_busy(state_s);
      case (state_r)
        IDLE, FOUND, EXHAUST: begin
          if (start_ok_s) begin
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
          end
        end
        LOAD: begin
          block_r <= bus.seq_data[MSG_W-1:NONCE_W];
          nonce_r <= NONCE_START;
        end
        REQ: begin
          if (bus.hash_done) digest_r <= bus.hash_digest;
        end
        CHECK: begin
          if (hit_s) begin
            nonce_out_r  <= nonce_r;
            digest_out_r <= digest_r;
            found_r      <= 1'b1;
          end else if (last_nonce_s) begin
            exhausted_r <= 1'b1;
          end else begin
            nonce_r <= nonce_r + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef NONCE_SEARCH_STATS_EN
  logic [NONCE_W-1:0] attempts_r;

  // Accepted hash results since the last start, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attempts_r <= {NONCE_W{1'b0}};
    end else if (state_r == LOAD) begin
      attempts_r <= {NONCE_W{1'b0}};
    end else if ((state_r == REQ) && bus.hash_done && (attempts_r != 32'hFFFF_FFFF)) begin
      attempts_r <= attempts_r + 32'd1;
    end
  end

  assign bus.attempts = attempts_r;
`endif

  assign bus.hash_req   = hash_req_r;
  assign bus.hash_msg   = {block_r, nonce_r};
  assign bus.busy       = busy_r;
  assign bus.found      = found_r;
  assign bus.exhausted  = exhausted_r;
  assign bus.nonce_out  = nonce_out_r;
  assign bus.digest_out = digest_out_r;

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Sits directly downstream of the 288-bit random-sequence generator.
- Takes the generator's {256-bit seed, 32-bit zero nonce field} output and runs a nonce search against an external hash core.
- For each try it inserts the current nonce into the low 32 bits, issues a hash request and compares the returned digest against a leading-zero difficulty target.
- Reports the first winning nonce and its digest, or exhaustion of the nonce space.

Parameters:
- DIFFICULTY, 8: number of leading (MSB) zero bits the digest needs to count as a hit. Legal range 0..256.
- NONCE_START, 32'h0000_0000: first nonce tried after a start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- seq_valid  in  1  generator done flag; seq_data is valid while high.
- seq_data  in  288  generator output; [287:32] is the seed, [31:0] is ignored.
- start  in  1  one-cycle request to begin a search.
- hash_req  out  1  hash request, held high until hash_done.
- hash_msg  out  288  message to hash: {block_reg, nonce}.
- hash_done  in  1  one-cycle pulse from the hash core; hash_digest is valid in the same cycle.
- hash_digest  in  256  digest returned by the hash core.
- busy  out  1  high in any state except IDLE, FOUND and EXHAUST.
- found  out  1  sticky hit flag.
- exhausted  out  1  sticky flag: all nonces tried, no hit.
- nonce_out  out  32  winning nonce, valid while found=1.
- digest_out  out  256  winning digest, valid while found=1.

Behaviour:
- Reset (asynchronous, active-high; clock clk):
  - state=IDLE.
  - All outputs and registers reset to 0, including hash_req and hash_msg.
  - Reset mid-search drops hash_req immediately. Any later hash_done is ignored.
- States: IDLE, LOAD, REQ, CHECK, FOUND, EXHAUST.
- IDLE/FOUND/EXHAUST:
  - If start=1 and seq_valid=1, go to LOAD and clear found and exhausted.
  - start with seq_valid=0 is ignored; the block stays in its current state and keeps its flags.
- LOAD (1 cycle): block_reg<=seq_data[287:32], nonce<=NONCE_START, then go to REQ.
- REQ:
  - hash_req=1 and hash_msg={block_reg,nonce}. Both are held stable for the whole state.
  - On hash_done=1: digest_reg<=hash_digest, go to CHECK. hash_req is low in CHECK.
- CHECK (1 cycle):
  - hit = (digest_reg[255:256-DIFFICULTY]==0). DIFFICULTY=0 is always a hit.
  - If hit: nonce_out<=nonce, digest_out<=digest_reg, found<=1, go to FOUND.
  - Else if nonce==32'hFFFF_FFFF: exhausted<=1, go to EXHAUST. The nonce does not wrap.
  - Else: nonce<=nonce+1 (32-bit), go to REQ.
- Latency:
  - start to first hash_req = 2 cycles (start sampled, then LOAD, then REQ).
  - Each try = hash core latency + 2 cycles (done sample, then CHECK).
- Ignored inputs and stability rules:
  - start while busy=1 is ignored.
  - hash_done outside REQ is ignored.
  - seq_data changing after LOAD has no effect.
  - hash_msg holds its last value outside REQ, and is 0 after reset.
- found and exhausted are never both 1. Each stays high until the next accepted start or reset.

Optional Feature:
- Macro: NONCE_SEARCH_STATS_EN.
- Defined:
  - Adds output port attempts [31:0]: count of hash_done pulses accepted in REQ since the last accepted start.
  - Cleared in LOAD and on reset; saturates at 32'hFFFF_FFFF.
  - Frozen in FOUND and EXHAUST.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package mining_pkg:
  - Constants SEED_W=256, NONCE_W=32, MSG_W=288, DIGEST_W=256.
  - Enum typedef search_state_t for the six states.
- One sub-module, target_compare:
  - Combinational.
  - Parameter DIFFICULTY; inputs digest[255:0]; output hit.
  - Instantiated once and used in CHECK.

Test Plan:
- DIFFICULTY=0, seq_data={256'hA5..A5,32'h0}, start, hash core returns any digest:
  - hash_msg={A5..A5,32'h0}.
  - found=1 and nonce_out=0 exactly 2 cycles after hash_done.
- DIFFICULTY=8, model returns digest[255:248]=8'h01 for nonces 0..4 and 8'h00 at nonce 5:
  - Exactly 6 hash_req/hash_done handshakes.
  - nonce_out=5, digest_out matches the nonce-5 digest, busy=0.
- NONCE_START=32'hFFFF_FFFE, digest never a hit:
  - Two tries (FFFF_FFFE, FFFF_FFFF), then exhausted=1, found=0, no third hash_req.
- start with seq_valid=0:
  - No state change, hash_req stays 0.
  - start pulses during REQ do not restart the search; nonce keeps incrementing.
- Reset asserted mid-REQ with hash_req=1:
  - hash_req, busy, found and exhausted drop to 0 without waiting for a clock edge.
  - A hash_done pulse after reset release has no effect.
- With NONCE_SEARCH_STATS_EN defined, the case-2 search gives attempts=6.
  - attempts returns to 0 on the next accepted start (LOAD).
